// File: rtl/control_unit_pepo_if.sv
// control_unit_pepo_if: status inputs from the datapath and the control word driven back to it
interface control_unit_pepo_if;
    logic [31:0] IR_OUT;
    logic        LSM_DETECT;
    logic        LSM_END;
    logic        MOC;
    logic        COND;
    logic [33:0] cu_datapath;
    logic [4:0]  STATE;

    modport master (
        input  IR_OUT, LSM_DETECT, LSM_END, MOC, COND,
        output cu_datapath, STATE
    );

    modport slave (
        output IR_OUT, LSM_DETECT, LSM_END, MOC, COND,
        input  cu_datapath, STATE
    );
endinterface

// File: rtl/control_unit_pepo.sv
// control_unit_pepo: hardwired Moore FSM producing the registered 34-bit datapath control word
module control_unit_pepo (
    input logic                 CLK,
    input logic                 RESET,
    control_unit_pepo_if.master bus
);
    localparam logic [4:0] OP_PASS_A  = 5'b10000;
    localparam logic [4:0] OP_PASS_B  = 5'b01101;
    localparam logic [4:0] OP_A_PLUS4 = 5'b10010;
    localparam logic [4:0] OP_ADD     = 5'b00100;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    typedef enum logic [4:0] {
        IDLE = 5'd0,  F0   = 5'd1,  F1   = 5'd2,  F2   = 5'd3,  F3   = 5'd4,
        DEC  = 5'd5,  DP   = 5'd6,  BL   = 5'd7,  BR   = 5'd8,  LS0  = 5'd9,
        LD1  = 5'd10, LD2  = 5'd11, ST1  = 5'd12, ST2  = 5'd13, LM0  = 5'd14,
        LM1  = 5'd15, LML  = 5'd16, LMR  = 5'd17, LMS  = 5'd18, LMS2 = 5'd19,
        LMA  = 5'd20, LMW  = 5'd21
    } state_t;

    state_t      state_q, state_d;
    logic [33:0] cw_q, cw_d;
    logic [31:0] ir;

    assign ir              = bus.IR_OUT;
    assign bus.cu_datapath = cw_q;
    assign bus.STATE       = state_q;

    // next-state selection; MOC only matters in wait states, COND only in DEC
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = F0;
            F0:      state_d = F1;
            F1:      state_d = F2;
            F2:      state_d = bus.MOC ? F3 : F2;
            F3:      state_d = DEC;
            DEC:     state_d = !bus.COND             ? F0 :
                               ir[27:26] == 2'b00    ? DP :
                               ir[27:26] == 2'b01    ? LS0 :
                               ir[27:25] == 3'b100   ? (bus.LSM_DETECT ? LM0 : F0) :
                               ir[27:25] == 3'b101   ? (ir[24] ? BL : BR) : F0;
            DP:      state_d = F0;
            BL:      state_d = BR;
            BR:      state_d = F0;
            LS0:     state_d = ir[20] ? LD1 : ST1;
            LD1:     state_d = bus.MOC ? LD2 : LD1;
            LD2:     state_d = F0;
            ST1:     state_d = ST2;
            ST2:     state_d = bus.MOC ? F0 : ST2;
            LM0:     state_d = LM1;
            LM1:     state_d = bus.LSM_END ? (ir[21] ? LMW : F0) : (ir[20] ? LML : LMS);
            LML:     state_d = bus.MOC ? LMR : LML;
            LMR:     state_d = LMA;
            LMS:     state_d = LMS2;
            LMS2:    state_d = bus.MOC ? LMA : LMS2;
            LMA:     state_d = LM1;
            LMW:     state_d = F0;
            default: state_d = IDLE;
        endcase
    end

    // control word of the state being entered, so it is registered alongside the state
    always_comb begin
        cw_d = '0;
        case (state_d)
            F0: begin
                cw_d[30] = 1'b1; cw_d[26:25] = 2'b01; cw_d[15:11] = OP_PASS_A;
            end
            F1: begin
                cw_d[32] = 1'b1; cw_d[26:25] = 2'b01; cw_d[21:19] = 3'b001; cw_d[15:11] = OP_A_PLUS4;
                cw_d[28:27] = 2'b11; cw_d[9:7] = SIZE_WORD;
            end
            F2: begin
                cw_d[28:27] = 2'b11; cw_d[9:7] = SIZE_WORD;
            end
            F3: begin
                cw_d[31] = 1'b1; cw_d[28:27] = 2'b11; cw_d[9:7] = SIZE_WORD;
            end
            DP: begin
                cw_d[33] = 1'b1; cw_d[32] = ir[24:23] != 2'b10;
                cw_d[21:19] = 3'b011; cw_d[18:17] = 2'b01;
            end
            BL: begin
                cw_d[32] = 1'b1; cw_d[26:25] = 2'b01; cw_d[21:19] = 3'b010; cw_d[15:11] = OP_PASS_A;
            end
            BR: begin
                cw_d[32] = 1'b1; cw_d[26:25] = 2'b01; cw_d[21:19] = 3'b001; cw_d[15:11] = OP_ADD;
            end
            LS0: begin
                cw_d[30] = 1'b1; cw_d[18:17] = 2'b10; cw_d[10] = 1'b1;
            end
            LD1: begin
                cw_d[29] = 1'b1; cw_d[28:27] = 2'b11; cw_d[16] = 1'b1; cw_d[10] = 1'b1;
                cw_d[2:1] = 2'b01; cw_d[0] = 1'b1;
            end
            LD2: begin
                cw_d[32] = 1'b1; cw_d[21:19] = 3'b011; cw_d[15:11] = OP_PASS_B;
            end
            ST1: begin
                cw_d[29] = 1'b1; cw_d[26:25] = 2'b11; cw_d[15:11] = OP_PASS_A;
            end
            ST2: begin
                cw_d[27] = 1'b1; cw_d[10] = 1'b1; cw_d[2:1] = 2'b01; cw_d[0] = 1'b1;
            end
            LM0: begin
                cw_d[30] = 1'b1; cw_d[18:17] = 2'b11; cw_d[6] = 1'b1; cw_d[5:3] = 3'b001;
            end
            LML: begin
                cw_d[29] = 1'b1; cw_d[28:27] = 2'b11; cw_d[16] = 1'b1; cw_d[2:1] = 2'b10;
            end
            LMR: begin
                cw_d[32] = 1'b1; cw_d[21:19] = 3'b100; cw_d[15:11] = OP_PASS_B;
            end
            LMS: begin
                cw_d[29] = 1'b1; cw_d[26:25] = 2'b10; cw_d[15:11] = OP_PASS_A;
            end
            LMS2: begin
                cw_d[27] = 1'b1; cw_d[2:1] = 2'b10;
            end
            LMA: begin
                cw_d[30] = 1'b1; cw_d[18:17] = 2'b11; cw_d[6] = 1'b1; cw_d[5:3] = 3'b010;
            end
            LMW:     cw_d[32] = 1'b1;
            default: cw_d = '0;
        endcase
    end

    // state and control word registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
        end
    end
endmodule
